spi_slave: RTL

Serial front end for the SPI-to-RAM path. It deserializes master frames on `MOSI` into 10-bit command words (`rx_data`/`rx_valid`) for the single-port RAM. For read-data frames, it waits for the RAM's `tx_data`/`tx_valid` and serializes the byte back on `MISO`. `clk` is the SPI clock; all sampling and driving occur on its rising edge.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_slave.sv | 117 +++++++++++
 2 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-to-RAM path: FSM states, command opcodes
// and default word widths.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_e;

  // Opcode in rx_data[9:8]; the RAM decodes these, the slave only forwards them.
  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  localparam int DEF_CMD_W  = 10;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/spi_slave.sv
// SPI slave: deserializes MOSI frames into command words for the RAM and
// serializes the RAM's read byte back on MISO for read-data frames.
module spi_slave
  import spi_pkg::*;
#(
  parameter int CMD_W  = DEF_CMD_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [CMD_W-1:0]  rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic [2:0]        dbg_state,
  output logic              dbg_rd_addr_seen
);

  localparam int BIT_CNT_W = $clog2(CMD_W);
  localparam int TX_CNT_W  = $clog2(DATA_W + 1);

  spi_state_e            state, state_nxt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [CMD_W-2:0]      shift_reg;
  logic                  rx_done;
  logic [DATA_W-1:0]     tx_shift;
  logic [TX_CNT_W-1:0]   tx_cnt;
  logic                  tx_loaded;
  logic                  tx_done;
  logic                  rd_addr_seen;

  assign dbg_state        = state;
  assign dbg_rd_addr_seen = rd_addr_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!SS_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              state_nxt = IDLE;
        else if (!MOSI)        state_nxt = WRITE;
        else if (rd_addr_seen) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (SS_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Receive and transmit datapath. SS_n high drops any partial word and
  // transmit progress but keeps rd_addr_seen so a read-data frame can be retried.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      shift_reg    <= '0;
      rx_done      <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      tx_loaded    <= 1'b0;
      tx_done      <= 1'b0;
      MISO         <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE || SS_n) begin
        bit_cnt   <= '0;
        rx_done   <= 1'b0;
        tx_cnt    <= '0;
        tx_loaded <= 1'b0;
        tx_done   <= 1'b0;
        MISO      <= 1'b0;
      end else if (state != CHK_CMD) begin
        if (!rx_done) begin
          shift_reg <= {shift_reg[CMD_W-3:0], MOSI};
          if (bit_cnt == BIT_CNT_W'(CMD_W - 1)) begin
            rx_data  <= {shift_reg, MOSI};
            rx_valid <= 1'b1;
            rx_done  <= 1'b1;
            bit_cnt  <= '0;
            if (state == READ_ADD) rd_addr_seen <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else if (state == READ_DATA && !rx_valid) begin
          // tx_valid is only looked at after the strobe cycle and before shifting starts.
          if (!tx_loaded) begin
            if (tx_valid) begin
              tx_shift  <= tx_data;
              tx_loaded <= 1'b1;
            end
          end else if (!tx_done) begin
            MISO     <= tx_shift[DATA_W-1];
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            tx_cnt   <= tx_cnt + 1'b1;
            if (tx_cnt == TX_CNT_W'(DATA_W - 1)) begin
              tx_done      <= 1'b1;
              rd_addr_seen <= 1'b0;
            end
          end else begin
            MISO <= 1'b0;
          end
        end
      end
    end
  end

endmodule
